// File: rtl/router_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : router_pkg                                                     |
// | Description : Shared flit layout, port indices and flit type for mesh_router.|
// | Revision    : 1.0 - initial release                                          |
// +-----------------------------------------------------------------------------+
package router_pkg;

    localparam int DX_HI  = 63;
    localparam int DX_LO  = 48;
    localparam int DY_HI  = 47;
    localparam int DY_LO  = 32;
    localparam int PAY_HI = 31;
    localparam int PAY_LO = 0;

    localparam int P_LEFT    = 0;
    localparam int P_RIGHT   = 1;
    localparam int P_UP      = 2;
    localparam int P_DOWN    = 3;
    localparam int P_LOCAL   = 4;
    localparam int NUM_PORTS = 5;
    localparam int PORT_W    = 3;

    typedef logic [PORT_W-1:0] port_idx_t;

    typedef struct packed {
        logic [DX_HI-DX_LO:0]   dest_x;
        logic [DY_HI-DY_LO:0]   dest_y;
        logic [PAY_HI-PAY_LO:0] payload;
    } flit_t;

endpackage
`default_nettype wire

// File: rtl/router_in_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : router_in_fifo                                                 |
// | Description : Synchronous input FIFO; a push on a full FIFO succeeds only    |
// |               when a pop frees a slot in the same cycle.                     |
// | Revision    : 1.0 - initial release                                          |
// +-----------------------------------------------------------------------------+
module router_in_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int              c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_AW:0]   c_FULL = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_rd;
    logic [c_AW-1:0]  r_wr;
    logic [c_AW:0]    r_cnt;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_cnt == '0);
    assign full      = (r_cnt == c_FULL);
    assign head      = r_mem[r_rd];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= din;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mesh_router.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : mesh_router                                                    |
// | Description : 5-port XY dimension-order mesh router with local inject/eject. |
// |               Optional ROUTER_DROP_CNT_EN adds an 8-bit saturating drop_cnt. |
// | Revision    : 1.0 - initial release                                          |
// +-----------------------------------------------------------------------------+
module mesh_router
    import router_pkg::*;
#(
    parameter int FLIT_W     = 64,
    parameter int DATA_W     = 32,
    parameter int COORD_W    = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] x_pos,
    input  logic [COORD_W-1:0] y_pos,
    input  logic [FLIT_W-1:0]  in_left,
    input  logic [FLIT_W-1:0]  in_right,
    input  logic [FLIT_W-1:0]  in_up,
    input  logic [FLIT_W-1:0]  in_down,
    input  logic [DATA_W-1:0]  from_cpu,
    input  logic [COORD_W-1:0] max_x,
    input  logic [COORD_W-1:0] max_y,
    input  logic               set_fi,
    output logic [FLIT_W-1:0]  out_left,
    output logic [FLIT_W-1:0]  out_right,
    output logic [FLIT_W-1:0]  out_up,
    output logic [FLIT_W-1:0]  out_down,
`ifdef ROUTER_DROP_CNT_EN
    output logic [7:0]         drop_cnt,
`endif
    output logic [DATA_W-1:0]  to_cpu
);

    logic [FLIT_W-1:0]    w_in_flit [NUM_PORTS];
    flit_t                w_head    [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_push;
    logic [NUM_PORTS-1:0] w_pop;
    logic [NUM_PORTS-1:0] w_full;
    logic [NUM_PORTS-1:0] w_empty;
    logic [NUM_PORTS-1:0] w_live;
    logic [NUM_PORTS-1:0] w_bad;
    port_idx_t            w_dir     [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_gnt_vld;
    port_idx_t            w_gnt_idx [NUM_PORTS];

    port_idx_t            r_ptr     [NUM_PORTS];
    logic [FLIT_W-1:0]    r_out     [P_LOCAL];
    logic [DATA_W-1:0]    r_to_cpu;

    // Local injection: destination nibbles of the CPU word are zero-extended.
    assign w_in_flit[P_LEFT]  = in_left;
    assign w_in_flit[P_RIGHT] = in_right;
    assign w_in_flit[P_UP]    = in_up;
    assign w_in_flit[P_DOWN]  = in_down;
    assign w_in_flit[P_LOCAL] = {{(COORD_W-4){1'b0}}, from_cpu[31:28],
                                 {(COORD_W-4){1'b0}}, from_cpu[27:24], from_cpu};

    assign w_push[P_LEFT]  = (in_left[DX_HI:DX_LO]  != '0);
    assign w_push[P_RIGHT] = (in_right[DX_HI:DX_LO] != '0);
    assign w_push[P_UP]    = (in_up[DX_HI:DX_LO]    != '0);
    assign w_push[P_DOWN]  = (in_down[DX_HI:DX_LO]  != '0);
    assign w_push[P_LOCAL] = set_fi && (from_cpu[31:28] != 4'h0);

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_fifo
        router_in_fifo #(
            .WIDTH (FLIT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (w_push[gi]),
            .din   (w_in_flit[gi]),
            .pop   (w_pop[gi]),
            .full  (w_full[gi]),
            .empty (w_empty[gi]),
            .head  (w_head[gi])
        );
    end

    // Route decode per head; invalid heads are flagged for discard instead.
    always_comb begin
        w_live = '0;
        w_bad  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_dir[i] = port_idx_t'(P_LOCAL);
            if (!w_empty[i]) begin
                if (w_head[i].dest_x > max_x || w_head[i].dest_y > max_y ||
                    w_head[i].dest_y == '0) begin
                    w_bad[i] = 1'b1;
                end else begin
                    w_live[i] = 1'b1;
                end
            end
            if (w_head[i].dest_x > x_pos) begin
                w_dir[i] = port_idx_t'(P_RIGHT);
            end else if (w_head[i].dest_x < x_pos) begin
                w_dir[i] = port_idx_t'(P_LEFT);
            end else if (w_head[i].dest_y > y_pos) begin
                w_dir[i] = port_idx_t'(P_DOWN);
            end else if (w_head[i].dest_y < y_pos) begin
                w_dir[i] = port_idx_t'(P_UP);
            end
        end
    end

    // Round-robin: search starts at the pointer and wraps through all inputs.
    always_comb begin
        logic [3:0] w_sum;
        port_idx_t  w_sel;
        w_sum = '0;
        w_sel = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_gnt_vld[o] = 1'b0;
            w_gnt_idx[o] = '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                w_sum = {1'b0, r_ptr[o]} + 4'(k);
                if (w_sum >= 4'(NUM_PORTS)) begin
                    w_sum = w_sum - 4'(NUM_PORTS);
                end
                w_sel = w_sum[PORT_W-1:0];
                if (!w_gnt_vld[o] && w_live[w_sel] && (w_dir[w_sel] == port_idx_t'(o))) begin
                    w_gnt_vld[o] = 1'b1;
                    w_gnt_idx[o] = w_sel;
                end
            end
        end
    end

    always_comb begin
        w_pop = w_bad;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (w_gnt_vld[o]) begin
                w_pop[w_gnt_idx[o]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                r_ptr[o] <= '0;
            end
            for (int o = 0; o < P_LOCAL; o++) begin
                r_out[o] <= '0;
            end
            r_to_cpu <= '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (w_gnt_vld[o]) begin
                    r_ptr[o] <= (w_gnt_idx[o] == port_idx_t'(NUM_PORTS-1)) ? '0
                                                                         : w_gnt_idx[o] + 1'b1;
                end
            end
            for (int o = 0; o < P_LOCAL; o++) begin
                r_out[o] <= w_gnt_vld[o] ? w_head[w_gnt_idx[o]] : '0;
            end
            if (w_gnt_vld[P_LOCAL]) begin
                r_to_cpu <= w_head[w_gnt_idx[P_LOCAL]].payload;
            end
        end
    end

    assign out_left  = r_out[P_LEFT];
    assign out_right = r_out[P_RIGHT];
    assign out_up    = r_out[P_UP];
    assign out_down  = r_out[P_DOWN];
    assign to_cpu    = r_to_cpu;

`ifdef ROUTER_DROP_CNT_EN
    logic [3:0] w_drop_n;
    logic [8:0] w_cnt_sum;
    logic [7:0] r_drop_cnt;

    // Overflow drops only when no same-cycle pop freed a slot.
    always_comb begin
        w_drop_n = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_drop_n = w_drop_n + 4'(w_bad[i]) + 4'(w_push[i] & w_full[i] & ~w_pop[i]);
        end
    end

    assign w_cnt_sum = {1'b0, r_drop_cnt} + 9'(w_drop_n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mesh_router.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_mesh_router                                                 |
// | Description : Directed self-checking bench for mesh_router at node (2,2)/3x3.|
// | Revision    : 1.0 - initial release                                          |
// +-----------------------------------------------------------------------------+
module tb_mesh_router;

    logic        clk;
    logic        rst_n;
    logic [15:0] x_pos, y_pos, max_x, max_y;
    logic [63:0] in_left, in_right, in_up, in_down;
    logic [31:0] from_cpu;
    logic        set_fi;
    logic [63:0] out_left, out_right, out_up, out_down;
    logic [31:0] to_cpu;
`ifdef ROUTER_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    mesh_router u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .in_left   (in_left),
        .in_right  (in_right),
        .in_up     (in_up),
        .in_down   (in_down),
        .from_cpu  (from_cpu),
        .max_x     (max_x),
        .max_y     (max_y),
        .set_fi    (set_fi),
        .out_left  (out_left),
        .out_right (out_right),
        .out_up    (out_up),
        .out_down  (out_down),
`ifdef ROUTER_DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .to_cpu    (to_cpu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_left  = '0;
        in_right = '0;
        in_up    = '0;
        in_down  = '0;
        from_cpu = '0;
        set_fi   = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        tick();
        rst_n = 1'b1;
    endtask

    logic [63:0] seq [8];

    initial begin
        x_pos = 16'd2;
        y_pos = 16'd2;
        max_x = 16'd3;
        max_y = 16'd3;
        clear_inputs();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_left",  out_left,  64'h0);
        chk("rst_out_right", out_right, 64'h0);
        chk("rst_out_up",    out_up,    64'h0);
        chk("rst_out_down",  out_down,  64'h0);
        chk("rst_to_cpu",    64'(to_cpu), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_outs", out_left | out_right | out_up | out_down, 64'h0);
        chk("idle_to_cpu", 64'(to_cpu), 64'h0);

        // Pass-through left -> right
        in_left = {16'd3, 16'd2, 32'hDEADBEEF};
        tick();
        in_left = '0;
        chk("pass_not_yet", out_right, 64'h0);
        tick();
        chk("pass_right", out_right, 64'h0003_0002_DEAD_BEEF);
        chk("pass_others", out_left | out_up | out_down, 64'h0);
        tick();
        chk("pass_one_cycle", out_right, 64'h0);

        // Eject
        in_up = {16'd2, 16'd2, 32'h00001234};
        tick();
        in_up = '0;
        tick();
        chk("eject_to_cpu", 64'(to_cpu), 64'h1234);
        chk("eject_no_out", out_left | out_right | out_up | out_down, 64'h0);
        tick();
        tick();
        chk("eject_hold", 64'(to_cpu), 64'h1234);

        // Inject
        set_fi   = 1'b1;
        from_cpu = 32'h130000AA;
        tick();
        clear_inputs();
        tick();
        chk("inject_left", out_left, 64'h0001_0003_1300_00AA);
        chk("inject_others", out_right | out_up | out_down, 64'h0);
        chk("inject_to_cpu", 64'(to_cpu), 64'h1234);

        // Injection with dest_x nibble 0 is ignored
        set_fi   = 1'b1;
        from_cpu = 32'h03000011;
        tick();
        clear_inputs();
        tick();
        chk("inject_empty", out_left | out_right | out_up | out_down, 64'h0);

        // Invalid destinations
        in_down = {16'd5, 16'd1, 32'h00000001};
        tick();
        in_down = '0;
        tick();
        chk("invalid_x_outs", out_left | out_right | out_up | out_down, 64'h0);
        tick();
        chk("invalid_x_outs2", out_left | out_right | out_up | out_down, 64'h0);
`ifdef ROUTER_DROP_CNT_EN
        chk("drop_cnt_1", 64'(drop_cnt), 64'd1);
`endif
        in_down = {16'd2, 16'd0, 32'h00000077};
        tick();
        in_down = '0;
        tick();
        tick();
        chk("invalid_y0_outs", out_left | out_right | out_up | out_down, 64'h0);
        chk("invalid_y0_cpu", 64'(to_cpu), 64'h1234);
`ifdef ROUTER_DROP_CNT_EN
        chk("drop_cnt_2", 64'(drop_cnt), 64'd2);
`endif

        // Contention from a fresh round-robin state
        apply_reset();
        in_left = {16'd3, 16'd2, 32'h000000A1};
        in_up   = {16'd3, 16'd2, 32'h000000A2};
        tick();
        clear_inputs();
        tick();
        chk("cont_first",  out_right, 64'h0003_0002_0000_00A1);
        tick();
        chk("cont_second", out_right, 64'h0003_0002_0000_00A2);
        tick();
        chk("cont_done",   out_right, 64'h0);

        // Two streams into one output: exercises push-on-full-with-pop and overflow drop
        apply_reset();
        for (int k = 1; k <= 4; k++) begin
            in_left = 64'h0003_0002_0000_0010 + 64'(k);
            in_up   = 64'h0003_0002_0000_0020 + 64'(k);
            tick();
        end
        clear_inputs();
        seq[0] = 64'h0003_0002_0000_0011;
        seq[1] = 64'h0003_0002_0000_0021;
        seq[2] = 64'h0003_0002_0000_0012;
        seq[3] = 64'h0003_0002_0000_0022;
        seq[4] = 64'h0003_0002_0000_0013;
        seq[5] = 64'h0003_0002_0000_0023;
        seq[6] = 64'h0003_0002_0000_0014;
        seq[7] = 64'h0;
        // First grant already appeared on the edge that captured the 2nd pair.
        chk("ovf_pre0", out_right, seq[2]);
        for (int k = 3; k < 8; k++) begin
            tick();
            chk($sformatf("ovf_seq%0d", k), out_right, seq[k]);
        end
`ifdef ROUTER_DROP_CNT_EN
        chk("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
`endif

        // Asynchronous reset in mid-operation
        apply_reset();
        in_up = {16'd2, 16'd2, 32'h00000055};
        tick();
        in_up   = '0;
        in_left = {16'd3, 16'd1, 32'h0000BEEF};
        tick();
        in_left = '0;
        chk("mid_to_cpu", 64'(to_cpu), 64'h55);
        tick();
        chk("mid_route_right", out_right, 64'h0003_0001_0000_BEEF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_right", out_right, 64'h0);
        chk("async_to_cpu", 64'(to_cpu), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", out_left | out_right | out_up | out_down, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
